// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per clock, fixed
// DATA_WIDTH-cycle latency, single-cycle register-file write on completion.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// CALC  | one shift-add / shift-subtract iteration per edge
// DONE  | one cycle: done=1, result/rd_out valid, we if rd != 0
module muldiv_unit #(
  parameter int DATA_WIDTH             = 32,
  parameter int REGISTER_ADDRESS_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              a_reset,
  input  logic                              start,
  input  logic [2:0]                        op,
  input  logic [DATA_WIDTH-1:0]             operand_a,
  input  logic [DATA_WIDTH-1:0]             operand_b,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] rd_in,
  output logic                              busy,
  output logic                              done,
  output logic [DATA_WIDTH-1:0]             result,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] rd_out,
  output logic                              we
);
  localparam int W = DATA_WIDTH;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [5:0] LAST_ITER = 6'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [5:0]                        iter_cnt;
  logic [2:0]                        op_q;
  logic [W-1:0]                      a_q, b_q;
  logic [REGISTER_ADDRESS_WIDTH-1:0] rd_q;
  logic [W-1:0]                      hi, lo, hi_nxt, lo_nxt;
  logic [W-1:0]                      mag_a_q, mag_b_q, final_res;
  logic [W:0]                        mul_sum, shifted;
  logic [W+1:0]                      trial;
  logic [2*W-1:0]                    product;
  logic                              neg_a, neg_b;

  function automatic logic a_signed(input logic [2:0] o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic is_signed);
    return (is_signed && x[W-1]) ? -x : x;
  endfunction

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    we        = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (iter_cnt == LAST_ITER) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        we        = (rd_out != '0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // lo holds the multiplier (mul) or the dividend bits still to shift in (div)
  always_comb begin
    neg_a   = a_signed(op_q) && a_q[W-1];
    neg_b   = b_signed(op_q) && b_q[W-1];
    mag_a_q = magnitude(a_q, a_signed(op_q));
    mag_b_q = magnitude(b_q, b_signed(op_q));
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag_a_q} : '0);
    shifted = {hi, lo[W-1]};
    trial   = {1'b0, shifted} - {2'b00, mag_b_q};
    if (op_q[2]) begin
      if (!trial[W+1]) begin
        hi_nxt = trial[W-1:0];
        lo_nxt = {lo[W-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[W-1:0];
        lo_nxt = {lo[W-2:0], 1'b0};
      end
    end else begin
      hi_nxt = mul_sum[W:1];
      lo_nxt = {mul_sum[0], lo[W-1:1]};
    end
    product = (neg_a ^ neg_b) ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    case (op_q)
      OP_MUL:           final_res = product[W-1:0];
      OP_DIV, OP_DIVU:  final_res = (b_q == '0) ? '1 : ((neg_a ^ neg_b) ? -lo_nxt : lo_nxt);
      OP_REM, 3'b111:   final_res = (b_q == '0) ? a_q : (neg_a ? -hi_nxt : hi_nxt);
      default:          final_res = product[2*W-1:W];
    endcase
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      iter_cnt <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      hi       <= '0;
      lo       <= '0;
      result   <= '0;
      rd_out   <= '0;
    end else if (state == IDLE && start) begin
      iter_cnt <= '0;
      op_q     <= op;
      a_q      <= operand_a;
      b_q      <= operand_b;
      rd_q     <= rd_in;
      hi       <= '0;
      lo       <= op[2] ? magnitude(operand_a, a_signed(op)) : magnitude(operand_b, b_signed(op));
    end else if (state == CALC) begin
      iter_cnt <= iter_cnt + 6'd1;
      hi       <= hi_nxt;
      lo       <= lo_nxt;
      if (iter_cnt == LAST_ITER) begin
        result <= final_res;
        rd_out <= rd_q;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: reference results from native 64-bit
// arithmetic are queued at accept and compared when done pulses.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        a_reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  rd_in;
  logic        busy, done, we;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  muldiv_unit #(.DATA_WIDTH(32), .REGISTER_ADDRESS_WIDTH(5)) dut (
    .clk(clk), .a_reset(a_reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we(we)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic   ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drive one operation, scramble inputs after accept, check latency and write.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input bit pulse_start);
    exp_t e;
    exp_t got_e;
    int   lat;
    int   extra_done;
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b; rd_in = r;
    @(posedge clk);
    e.res = model(o, a, b); e.rd = r; e.we = (r != 0);
    sb_q.push_back(e);
    #1;
    start = 1'b0;
    op = 3'($urandom); operand_a = $urandom; operand_b = $urandom; rd_in = 5'($urandom);
    check_val("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = pulse_start && (k == 4 || k == 31);
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    check_val("latency", lat, 32'd32);
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got_e = sb_q.pop_front();
      check_val("result", result, got_e.res);
      check_val("rd_out", 32'(rd_out), 32'(got_e.rd));
      check_val("we", 32'(we), 32'(got_e.we));
      check_val("busy_in_done", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check_val("done_drop", 32'(done), 32'd0);
      check_val("we_drop", 32'(we), 32'd0);
      check_val("busy_drop", 32'(busy), 32'd0);
      check_val("result_hold", result, got_e.res);
      check_val("rd_hold", 32'(rd_out), 32'(got_e.rd));
    end
    if (pulse_start) begin
      extra_done = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (done || busy) extra_done++;
      end
      check_val("ignored_start_no_activity", extra_done, 32'd0);
    end
  endtask

  initial begin
    int spurious;
    a_reset = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_we", 32'(we), 32'd0);
    check_val("rst_result", result, 32'd0);
    check_val("rst_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    a_reset = 1'b0;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    do_op(3'd5, 32'd100, 32'd0, 5'd7, 1'b0);
    do_op(3'd7, 32'd100, 32'd0, 5'd8, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd11, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd12, 1'b0);
    do_op(3'd0, 32'd1234, 32'd5678, 5'd0, 1'b0);
    do_op(3'd5, 32'd1000, 32'd7, 5'd13, 1'b1);

    // reset in the middle of a DIV aborts it without any write
    @(negedge clk);
    start = 1'b1; op = 3'd4; operand_a = 32'd50; operand_b = 32'd3; rd_in = 5'd14;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    a_reset = 1'b1;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_we", 32'(we), 32'd0);
    check_val("abort_result", result, 32'd0);
    @(negedge clk);
    a_reset = 1'b0;
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || we) spurious++;
    end
    check_val("abort_no_done", spurious, 32'd0);
    do_op(3'd4, 32'd50, 32'd3, 5'd14, 1'b0);

    for (int i = 0; i < 10; i++)
      do_op(3'($urandom), $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom,
            5'($urandom), 1'b0);

    check_val("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter REGISTER_ADDRESS_WIDTH, default 5, destination register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port a_reset  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-006 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port operand_a  input  DATA_WIDTH  rs1 value from register file read port 1.
REQ-008 SHALL have port operand_b  input  DATA_WIDTH  rs2 value from register file read port 2.
REQ-009 SHALL have port rd_in  input  REGISTER_ADDRESS_WIDTH  destination register index.
REQ-010 SHALL have port busy  output  1  high in CALC and DONE.
REQ-011 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port result  output  DATA_WIDTH  to register file write_data.
REQ-013 SHALL have port rd_out  output  REGISTER_ADDRESS_WIDTH  to register file write address.
REQ-014 SHALL have port we  output  1  to register file write enable.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-016 In IDLE, start=1 at edge e0 SHALL capture op, operand_a, operand_b, rd_in, clear 6-bit iteration counter, enter CALC.
REQ-017 Inputs after e0 SHALL NOT affect the operation in progress.
REQ-018 start while busy=1 SHALL be ignored: no queueing, no state change.
REQ-019 CALC SHALL perform one radix-2 iteration per edge, e1..e32 (32 iterations), entering DONE at e32.
REQ-020 Multiply: shift-add on magnitudes, 2*DATA_WIDTH-bit product, sign fixed after last iteration; MUL low word, MULH/MULHSU/MULHU high word with signed*signed, signed*unsigned, unsigned*unsigned.
REQ-021 Divide: restoring shift-subtract on magnitudes; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a), for signed ops only.
REQ-022 Divisor 0: DIV/DIVU result all ones, REM/REMU result operand_a; latency unchanged.
REQ-023 Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV result 0x80000000, REM result 0; latency unchanged.
REQ-024 DONE SHALL last exactly one cycle (e32 to e33): done=1, result and rd_out valid, we=1 iff captured rd != 0.
REQ-025 At e33 SHALL return to IDLE; done and we drop to 0; result and rd_out hold last values until next DONE.
REQ-026 start=1 during the DONE cycle SHALL be ignored; earliest acceptance at e33's following edge only if start still high in IDLE.
REQ-027 Fixed latency: done asserted exactly 32 edges after the accepting edge, all ops and operand values.
REQ-028 we SHALL never be 1 outside DONE.

Reset
REQ-029 a_reset=1 SHALL asynchronously force IDLE, counter 0, busy=0, done=0, we=0, result=0, rd_out=0.
REQ-030 a_reset asserted during CALC or DONE SHALL abort the operation with no write issued; the register file is not written.
REQ-031 After a_reset deasserts, first start SHALL be accepted at the first rising edge with start=1.

Verification
REQ-032 MUL a=7, b=-3 (0xFFFFFFFD), rd=5 -> done 32 edges after accept, result 0xFFFFFFEB, rd_out=5, we=1 for one cycle.
REQ-033 MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-034 DIV a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=100, b=0 -> 0xFFFFFFFF; REMU a=100, b=0 -> 100; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-035 Accept with rd=0 -> done=1, we=0; start pulsed at edges e5 and e32 of an operation -> ignored, busy unchanged, single done.
REQ-036 a_reset pulsed at edge e10 of a DIV -> busy, done, we, result drop to 0 immediately; no done follows; next start completes normally.
